issue_buffer: RTL and testbench

ISSUE_BUFFER -- requirements
Module: issue_buffer

---
 rtl/issue_pkg.sv | 31 +++
 rtl/issue_hazard_check.sv | 22 ++
 rtl/issue_buffer.sv | 93 +++++++++
 tb/tb_issue_buffer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared entry layout, MIPS field positions and decode helper for the issue buffer.
package issue_pkg;

   localparam int ISSUE_ENTRY_W = 64;

   localparam int PC_MSB   = 63;
   localparam int PC_LSB   = 32;
   localparam int INST_MSB = 31;
   localparam int INST_LSB = 0;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 26;
   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;
   localparam int RD_MSB = 15;
   localparam int RD_LSB = 11;

   localparam logic [5:0] OP_RTYPE = 6'b000000;

   typedef logic [4:0] reg_idx_t;

   // R-type writes rd, everything else is treated as writing rt.
   function automatic reg_idx_t dest_reg(input logic [5:0] opcode,
                                         input reg_idx_t rt,
                                         input reg_idx_t rd);
      return (opcode == OP_RTYPE) ? rd : rt;
   endfunction

endpackage

// File: rtl/issue_hazard_check.sv
// Combinational RAW check between the two oldest buffered instructions.
module issue_hazard_check
   import issue_pkg::*;
(
   input  logic [31:0] inst1,
   input  logic [31:0] inst2,
   output logic        hazard
);

   reg_idx_t dest1;
   logic     unused_bits;

   always_comb begin
      dest1  = dest_reg(inst1[OP_MSB:OP_LSB], inst1[RT_MSB:RT_LSB], inst1[RD_MSB:RD_LSB]);
      hazard = (dest1 != '0) &&
               ((dest1 == inst2[RS_MSB:RS_LSB]) || (dest1 == inst2[RT_MSB:RT_LSB]));
   end

   assign unused_bits = ^{inst1[RS_MSB:RS_LSB], inst1[RD_LSB-1:0],
                          inst2[OP_MSB:OP_LSB], inst2[RT_LSB-1:0]};

endmodule

// File: rtl/issue_buffer.sv
// Circular FWFT issue buffer: two-wide fetch writes, one- or two-wide decode reads.
// Dual issue (with hazard check) is enabled by defining ISSUE_DUAL_ISSUE_EN.
module issue_buffer
   import issue_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int ENTRY_W = ISSUE_ENTRY_W
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   w_en_1,
   input  logic                   w_en_2,
   input  logic [ENTRY_W-1:0]     w_data_1,
   input  logic [ENTRY_W-1:0]     w_data_2,
   output logic                   w_ready,
   input  logic                   id_ready,
   output logic [31:0]            id_pc_1,
   output logic [31:0]            id_inst_1,
   output logic                   id_en_1,
   output logic [31:0]            id_pc_2,
   output logic [31:0]            id_inst_2,
   output logic                   id_en_2,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [PTR_W-1:0]   rd_ptr_p1, wr_ptr_p1;
   logic [1:0]         n_wr, n_pop;

   assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
   assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

   assign w_ready   = (count <= CNT_W'(DEPTH - 2));
   assign id_en_1   = (count >= CNT_W'(1));

   assign id_pc_1   = mem[rd_ptr][PC_MSB:PC_LSB];
   assign id_inst_1 = mem[rd_ptr][INST_MSB:INST_LSB];
   assign id_pc_2   = mem[rd_ptr_p1][PC_MSB:PC_LSB];
   assign id_inst_2 = mem[rd_ptr_p1][INST_MSB:INST_LSB];

`ifdef ISSUE_DUAL_ISSUE_EN
   logic hazard;

   issue_hazard_check u_hazard (
      .inst1  (id_inst_1),
      .inst2  (id_inst_2),
      .hazard (hazard)
   );

   assign id_en_2 = (count >= CNT_W'(2)) && id_en_1 && !hazard;
`else
   assign id_en_2 = 1'b0;
`endif

   always_comb begin
      n_wr  = '0;
      n_pop = '0;
      if (w_ready)
         n_wr = {1'b0, w_en_1} + {1'b0, w_en_2};
      if (id_ready)
         n_pop = {1'b0, id_en_1} + {1'b0, id_en_2};
   end

   // A lone strobe (either slot) always lands at wr_ptr so entries stay contiguous.
   always_ff @(posedge clk) begin
      if (n_wr != 2'd0)
         mem[wr_ptr] <= w_en_1 ? w_data_1 : w_data_2;
      if (n_wr == 2'd2)
         mem[wr_ptr_p1] <= w_data_2;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + PTR_W'(n_pop);
         wr_ptr <= wr_ptr + PTR_W'(n_wr);
         count  <= count + CNT_W'(n_wr) - CNT_W'(n_pop);
      end
   end

endmodule

// File: tb/tb_issue_buffer.sv
// Randomized bench for issue_buffer against a queue-based reference model.
module tb_issue_buffer;
   import issue_pkg::*;

   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;
`ifdef ISSUE_DUAL_ISSUE_EN
   localparam bit DUAL = 1'b1;
`else
   localparam bit DUAL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, w_en_1, w_en_2, id_ready;
   logic [63:0]   w_data_1, w_data_2;
   logic          w_ready, id_en_1, id_en_2;
   logic [31:0]   id_pc_1, id_inst_1, id_pc_2, id_inst_2;
   logic [CW-1:0] count;
   logic [31:0]   hz_i1, hz_i2;
   logic          hz_out;

   int          checks   = 0;
   int          failures = 0;
   logic [63:0] mq[$];
   logic [31:0] next_pc = 32'h1000;

   issue_buffer #(.DEPTH(DEPTH), .ENTRY_W(64)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .w_en_1(w_en_1), .w_en_2(w_en_2), .w_data_1(w_data_1), .w_data_2(w_data_2),
      .w_ready(w_ready), .id_ready(id_ready),
      .id_pc_1(id_pc_1), .id_inst_1(id_inst_1), .id_en_1(id_en_1),
      .id_pc_2(id_pc_2), .id_inst_2(id_inst_2), .id_en_2(id_en_2),
      .count(count)
   );

   issue_hazard_check u_hz (.inst1(hz_i1), .inst2(hz_i2), .hazard(hz_out));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_hazard(input logic [31:0] i1, input logic [31:0] i2);
      int unsigned d, s, t;
      if ((i1 >> 26) == 0) d = (i1 >> 11) & 31;
      else                 d = (i1 >> 16) & 31;
      s = (i2 >> 21) & 31;
      t = (i2 >> 16) & 31;
      return (d != 0) && (d == s || d == t);
   endfunction

   function automatic logic [31:0] gen_inst();
      logic [4:0] a, b, c;
      a = 5'($urandom_range(0, 3));
      b = 5'($urandom_range(0, 3));
      c = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) return {6'd0, a, b, c, 5'd0, 6'h21};
      return {6'h09, a, b, 16'($urandom)};
   endfunction

   function automatic logic [63:0] new_entry();
      logic [63:0] e;
      e = {next_pc, gen_inst()};
      next_pc = next_pc + 32'd4;
      return e;
   endfunction

   function automatic bit model_en2();
      logic [63:0] a, b;
      if (mq.size() < 2) return 1'b0;
      a = mq[0];
      b = mq[1];
      return DUAL && !model_hazard(a[31:0], b[31:0]);
   endfunction

   task automatic compare_all(input string ctx);
      int n;
      logic [63:0] e;
      n = mq.size();
      check_eq({ctx, ":count"}, 64'(count), 64'(n));
      check_eq({ctx, ":w_ready"}, 64'(w_ready), 64'((DEPTH - n) >= 2));
      check_eq({ctx, ":id_en_1"}, 64'(id_en_1), 64'(n >= 1));
      check_eq({ctx, ":id_en_2"}, 64'(id_en_2), 64'(model_en2()));
      if (n >= 1) begin
         e = mq[0];
         check_eq({ctx, ":id_pc_1"}, 64'(id_pc_1), 64'(e[63:32]));
         check_eq({ctx, ":id_inst_1"}, 64'(id_inst_1), 64'(e[31:0]));
      end
      if (n >= 2) begin
         e = mq[1];
         check_eq({ctx, ":id_pc_2"}, 64'(id_pc_2), 64'(e[63:32]));
         check_eq({ctx, ":id_inst_2"}, 64'(id_inst_2), 64'(e[31:0]));
      end
   endtask

   // Drive one cycle from a negedge, advance the model, then compare at the next negedge.
   task automatic cycle(input string ctx, input bit f, input bit e1, input bit e2,
                        input logic [63:0] d1, input logic [63:0] d2, input bit rdy);
      int  n, pops;
      bit  writable;
      flush = f; w_en_1 = e1; w_en_2 = e2; w_data_1 = d1; w_data_2 = d2; id_ready = rdy;
      n = mq.size();
      if (f) begin
         mq.delete();
      end else begin
         writable = (DEPTH - n) >= 2;
         pops = 0;
         if (rdy && n >= 1) pops = model_en2() ? 2 : 1;
         repeat (pops) void'(mq.pop_front());
         if (writable && e1) mq.push_back(d1);
         if (writable && e2) mq.push_back(d2);
      end
      @(posedge clk);
      @(negedge clk);
      flush = 1'b0; w_en_1 = 1'b0; w_en_2 = 1'b0; id_ready = 1'b0;
      compare_all(ctx);
   endtask

   localparam logic [31:0] ADDU_3_1_2 = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
   localparam logic [31:0] ADDU_4_5_6 = {6'd0, 5'd5, 5'd6, 5'd4, 5'd0, 6'h21};
   localparam logic [31:0] ADDU_4_3_6 = {6'd0, 5'd3, 5'd6, 5'd4, 5'd0, 6'h21};
   localparam logic [31:0] ADDU_0_1_2 = {6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'h21};

   initial begin
      rst = 1'b1; flush = 1'b0; w_en_1 = 1'b0; w_en_2 = 1'b0; id_ready = 1'b0;
      w_data_1 = '0; w_data_2 = '0; hz_i1 = '0; hz_i2 = '0;
      repeat (2) @(negedge clk);
      compare_all("reset");
      rst = 1'b0;
      @(negedge clk);
      compare_all("post_reset");

      // Hazard sub-module, directed then random.
      hz_i1 = ADDU_3_1_2; hz_i2 = ADDU_4_3_6; #1;
      check_eq("hz_raw", 64'(hz_out), 64'd1);
      hz_i1 = ADDU_0_1_2; #1;
      check_eq("hz_dest0", 64'(hz_out), 64'd0);
      for (int i = 0; i < 200; i++) begin
         hz_i1 = gen_inst(); hz_i2 = gen_inst(); #1;
         check_eq("hz_rand", 64'(hz_out), 64'(model_hazard(hz_i1, hz_i2)));
      end

      // Single-slot write on slot 2 into an empty buffer.
      cycle("single_w2", 0, 0, 1, '0, {32'h200, ADDU_3_1_2}, 0);
      check_eq("single_w2_pc", 64'(id_pc_1), 64'h200);
      check_eq("single_w2_cnt", 64'(count), 64'd1);
      cycle("drain", 0, 0, 0, '0, '0, 1);

      // Independent pair: dual issue when enabled.
      cycle("dual_wr", 0, 1, 1, {32'h100, ADDU_3_1_2}, {32'h104, ADDU_4_5_6}, 0);
      check_eq("dual_pc2", 64'(id_pc_2), 64'h104);
      check_eq("dual_en2", 64'(id_en_2), 64'(DUAL));
      cycle("dual_pop", 0, 0, 0, '0, '0, 1);
      check_eq("dual_cnt", 64'(count), DUAL ? 64'd0 : 64'd1);
      cycle("drain", 0, 0, 0, '0, '0, 1);

      // RAW pair issues one at a time; same pair with dest $0 dual-issues.
      cycle("haz_wr", 0, 1, 1, {32'h100, ADDU_3_1_2}, {32'h104, ADDU_4_3_6}, 0);
      check_eq("haz_en2", 64'(id_en_2), 64'd0);
      cycle("haz_pop1", 0, 0, 0, '0, '0, 1);
      check_eq("haz_next_pc", 64'(id_pc_1), 64'h104);
      cycle("haz_pop2", 0, 0, 0, '0, '0, 1);
      cycle("nohaz_wr", 0, 1, 1, {32'h100, ADDU_0_1_2}, {32'h104, ADDU_4_3_6}, 0);
      check_eq("nohaz_en2", 64'(id_en_2), 64'(DUAL));
      cycle("nohaz_pop", 0, 0, 0, '0, '0, 1);
      cycle("drain", 0, 0, 0, '0, '0, 1);

      // Reset mid-stream with 5 entries held.
      cycle("rst_fill", 0, 1, 1, new_entry(), new_entry(), 0);
      cycle("rst_fill", 0, 1, 1, new_entry(), new_entry(), 0);
      cycle("rst_fill", 0, 1, 0, new_entry(), '0, 0);
      rst = 1'b1; #1;
      mq.delete();
      check_eq("midrst_cnt", 64'(count), 64'd0);
      check_eq("midrst_en1", 64'(id_en_1), 64'd0);
      check_eq("midrst_wready", 64'(w_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compare_all("after_midrst");

      // Fill to 15, drop a write, then stream across the pointer wrap.
      for (int i = 0; i < 7; i++) cycle("fill", 0, 1, 1, new_entry(), new_entry(), 0);
      cycle("fill", 0, 1, 0, new_entry(), '0, 0);
      check_eq("full_cnt", 64'(count), 64'd15);
      check_eq("full_wready", 64'(w_ready), 64'd0);
      cycle("full_drop", 0, 1, 1, {32'hdead, 32'h0}, {32'hbeef, 32'h0}, 0);
      check_eq("full_drop_cnt", 64'(count), 64'd15);
      for (int i = 0; i < 40; i++) cycle("wrap", 0, 1, 1, new_entry(), new_entry(), 1);
      for (int i = 0; i < 20; i++) cycle("wrap_drain", 0, 0, 0, '0, '0, 1);
      check_eq("wrap_empty", 64'(count), 64'd0);

      // Flush collides with write and pop.
      for (int i = 0; i < 3; i++) cycle("fl_fill", 0, 1, 1, new_entry(), new_entry(), 0);
      check_eq("fl_cnt6", 64'(count), 64'd6);
      cycle("flush", 1, 1, 1, new_entry(), new_entry(), 1);
      check_eq("flush_cnt", 64'(count), 64'd0);
      check_eq("flush_en1", 64'(id_en_1), 64'd0);
      cycle("post_flush", 0, 1, 0, {32'h300, ADDU_3_1_2}, '0, 0);
      check_eq("post_flush_pc", 64'(id_pc_1), 64'h300);

      // Random traffic.
      for (int i = 0; i < 400; i++)
         cycle("rand", ($urandom_range(0, 31) == 0),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0),
               new_entry(), new_entry(), ($urandom_range(0, 2) != 0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
